// File: rtl/crc_pkg.sv
// Shared constants, FSM encoding and bit-order helper for the CRC engine.
// Polynomials are given in normal form, right-aligned in 32 bits.
package crc_pkg;

  localparam logic [31:0] CRC32_POLY       = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32C_POLY      = 32'h1EDC_6F41;
  localparam logic [31:0] CRC16_CCITT_POLY = 32'h0000_1021;

  typedef logic [1:0] crc_state_t;

  localparam crc_state_t ST_IDLE  = 2'd0;
  localparam crc_state_t ST_ACCUM = 2'd1;
  localparam crc_state_t ST_DONE  = 2'd2;

  // Reverses the low 'width' bits of value; the result is right-aligned.
  function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int width);
    logic [31:0] result;
    result = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) result = {result[30:0], value[i]};
    end
    return result;
  endfunction

endpackage

// File: rtl/crc_byte_step.sv
// One byte of serial CRC update, unrolled into combinational logic.
// The register is kept in normal (MSB-first) orientation in every mode.
module crc_byte_step
  import crc_pkg::*;
#(
  parameter int          CRC_W      = 32,
  parameter logic [31:0] POLY       = CRC32_POLY,
  parameter bit          REFLECT_IN = 1'b1
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic [7:0]       data,
  output logic [CRC_W-1:0] crc_out
);

  logic [CRC_W-1:0] crc;
  logic             feedback;

  // NOTE: blocking assignments here model the bit-serial chain inside one
  // combinational evaluation; every variable gets a value first, so no latch.
  always_comb begin
    crc      = crc_in;
    feedback = 1'b0;
    for (int b = 0; b < 8; b++) begin
      feedback = crc[CRC_W-1] ^ (REFLECT_IN ? data[b] : data[7-b]);
      crc      = {crc[CRC_W-2:0], 1'b0} ^ (feedback ? POLY[CRC_W-1:0] : '0);
    end
    crc_out = crc;
  end

endmodule

// File: rtl/crc_engine.sv
// Streaming CRC engine: one beat of DATA_W bits per clock, result registered
// one cycle after the last beat and held until the consumer takes it.
module crc_engine
  import crc_pkg::*;
#(
  parameter int          CRC_W       = 32,
  parameter logic [31:0] POLY        = CRC32_POLY,
  parameter logic [31:0] INIT        = 32'hFFFF_FFFF,
  parameter logic [31:0] XOR_OUT     = 32'hFFFF_FFFF,
  parameter bit          REFLECT_IN  = 1'b1,
  parameter bit          REFLECT_OUT = 1'b1,
  parameter int          DATA_W      = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  input  logic [DATA_W/8-1:0] s_keep,
  input  logic                s_first,
  input  logic                s_last,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [CRC_W-1:0]    m_crc,
  output logic                m_err
);

  localparam int NB = DATA_W / 8;

  crc_state_t       state;
  logic             ready_en;
  logic [CRC_W-1:0] crc_reg;
  logic [CRC_W-1:0] crc_base;
  logic [CRC_W-1:0] crc_next;
  logic [CRC_W-1:0] crc_final;
  logic [31:0]      crc_reflected;
  logic [NB-1:0]    keep_prefix;
  logic [NB-1:0]    byte_en;
  logic             keep_run;
  logic             keep_err;
  logic             beat_acc;
  logic             result_take;

  assign s_ready     = ready_en && (state != ST_DONE);
  assign m_valid     = (state == ST_DONE);
  assign beat_acc    = s_valid && s_ready;
  assign result_take = m_valid && m_ready;

  // Bytes are only honoured up to the first cleared keep bit.
  always_comb begin
    keep_run    = 1'b1;
    keep_prefix = '0;
    for (int i = 0; i < NB; i++) begin
      keep_run       = keep_run & s_keep[i];
      keep_prefix[i] = keep_run;
    end
  end

  assign byte_en  = s_last ? keep_prefix : '1;
  assign keep_err = (s_keep != keep_prefix);
  assign crc_base = ((state == ST_IDLE) || s_first) ? INIT[CRC_W-1:0] : crc_reg;

  for (genvar g = 0; g < NB; g++) begin : g_step
    logic [CRC_W-1:0] crc_in;
    logic [CRC_W-1:0] crc_out;
    logic [CRC_W-1:0] crc_sel;

    if (g == 0) begin : g_head
      assign crc_in = crc_base;
    end else begin : g_link
      assign crc_in = g_step[g-1].crc_sel;
    end

    crc_byte_step #(
      .CRC_W      (CRC_W),
      .POLY       (POLY),
      .REFLECT_IN (REFLECT_IN)
    ) u_step (
      .crc_in  (crc_in),
      .data    (s_data[8*g +: 8]),
      .crc_out (crc_out)
    );

    assign crc_sel = byte_en[g] ? crc_out : crc_in;
  end

  assign crc_next      = g_step[NB-1].crc_sel;
  assign crc_reflected = bit_reverse(32'(crc_next), CRC_W);
  assign crc_final     = (REFLECT_OUT ? crc_reflected[CRC_W-1:0] : crc_next)
                         ^ XOR_OUT[CRC_W-1:0];

  // NOTE: s_ready comes from a flop so it stays low until the first clock
  // edge after reset is released, even though the state is already IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      ready_en <= 1'b0;
      crc_reg  <= INIT[CRC_W-1:0];
      m_crc    <= '0;
      m_err    <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (beat_acc) begin
            crc_reg <= crc_next;
            if (s_last) begin
              state <= ST_DONE;
              m_crc <= crc_final;
              m_err <= keep_err;
            end else begin
              state <= ST_ACCUM;
            end
          end
        end
        ST_DONE: begin
          if (result_take) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
